// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle shared by the SPI controller and its bench.
// Latency: none (wires only).
// Backpressure: carries stall; the SPI controller never stalls.
// Signals: cyc/stb/we/addr/wdata/sel from the requester; rdata/ack/stall/err/rty from the responder.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        err;
    logic        rty;

    modport SLAVE (
        input  cyc, stb, we, addr, wdata, sel,
        output rdata, ack, stall, err, rty
    );

    modport MASTER (
        output cyc, stb, we, addr, wdata, sel,
        input  rdata, ack, stall, err, rty
    );
endinterface

// File: rtl/wb_spi_ctrl.sv
// Wishbone-attached SPI master moving one byte per DATA write (CTRL/DIV/DATA/STATUS registers).
// Latency: bus ack one cycle after acceptance; a transfer takes 16*(div+1) cycles.
// Backpressure: none; stall is tied low, every cyc&stb cycle is accepted and acked.
// Ports: clk_i, rstn_i (async active-low), wb_if (Wishbone responder),
//        spi_sclk_o/spi_mosi_o/spi_miso_i/spi_cs_n_o (SPI pins), irq_o (level interrupt).
module wb_spi_ctrl #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    wishbone_if.SLAVE  wb_if,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_n_o,
    output logic       irq_o
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_DIV    = 2'd1;
    localparam logic [1:0] A_DATA   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_e      state_q, state_d;
    logic        cs_assert_q, cs_assert_d;
    logic        irq_en_q, irq_en_d;
    logic        cpol_q, cpol_d;
    logic [7:0]  div_q, div_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        wr_col_q, wr_col_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [3:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic        rd_req;
    logic        wr_en;
    logic        busy;
    logic        data_rd;
    logic [1:0]  reg_sel;
    logic        unused_bits;

    assign req     = wb_if.cyc & wb_if.stb;
    assign rd_req  = req & ~wb_if.we;
    assign wr_en   = req & wb_if.we & wb_if.sel[0];
    assign reg_sel = wb_if.addr[3:2];
    assign busy    = (state_q == XFER);
    assign data_rd = rd_req && (reg_sel == A_DATA);

    assign unused_bits = ^{wb_if.addr[31:4], wb_if.addr[1:0], wb_if.wdata[31:8], wb_if.sel[3:1]};

    always_comb begin
        state_d     = state_q;
        cs_assert_d = cs_assert_q;
        irq_en_d    = irq_en_q;
        cpol_d      = cpol_q;
        div_d       = div_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        wr_col_d    = wr_col_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_byte_d   = rx_byte_q;
        edge_cnt_d  = edge_cnt_q;
        div_cnt_d   = div_cnt_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ack_d       = req;
        rdata_d     = '0;

        // Read data is captured from the pre-update state, so a read that
        // coincides with completion returns the old rx byte.
        if (rd_req) begin
            unique case (reg_sel)
                A_CTRL:   rdata_d = {29'b0, cpol_q, irq_en_q, cs_assert_q};
                A_DIV:    rdata_d = {24'b0, div_q};
                A_DATA:   rdata_d = {24'b0, rx_byte_q};
                A_STATUS: rdata_d = {28'b0, wr_col_q, overrun_q, rx_valid_q, busy};
                default:  rdata_d = '0;
            endcase
        end
        if (data_rd) begin
            rx_valid_d = 1'b0;
        end

        if (wr_en) begin
            unique case (reg_sel)
                A_CTRL: begin
                    cs_assert_d = wb_if.wdata[0];
                    irq_en_d    = wb_if.wdata[1];
                    if (!busy) begin
                        cpol_d = wb_if.wdata[2];
                    end
                end
                A_DIV: begin
                    if (!busy) begin
                        div_d = wb_if.wdata[7:0];
                    end
                end
                A_DATA: begin
                    if (!busy) begin
                        state_d    = XFER;
                        tx_sr_d    = wb_if.wdata[7:0];
                        mosi_d     = wb_if.wdata[7];
                        edge_cnt_d = '0;
                        div_cnt_d  = '0;
                    end else begin
                        wr_col_d = 1'b1;
                    end
                end
                A_STATUS: begin
                    if (wb_if.wdata[2]) overrun_d = 1'b0;
                    if (wb_if.wdata[3]) wr_col_d  = 1'b0;
                end
                default: ;
            endcase
        end

        if (busy) begin
            // cpol and div cannot change while busy, so the live registers
            // hold the values captured at transfer start.
            if (div_cnt_q == div_q) begin
                div_cnt_d  = '0;
                sclk_d     = ~sclk_q;
                edge_cnt_d = edge_cnt_q + 4'd1;
                // edge_cnt_q counts edges already made; the one being made
                // now is edge_cnt_q+1, odd when edge_cnt_q is even.
                if (!edge_cnt_q[0]) begin
                    rx_sr_d = {rx_sr_q[6:0], spi_miso_i};
                end else if (edge_cnt_q != 4'd15) begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    mosi_d  = tx_sr_q[6];
                end else begin
                    state_d    = IDLE;
                    sclk_d     = cpol_q;
                    rx_byte_d  = rx_sr_q;
                    // A coincident DATA read consumes the old byte, so
                    // nothing unread is lost in that case.
                    if (rx_valid_q && !data_rd) begin
                        overrun_d = 1'b1;
                    end
                    rx_valid_d = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end else begin
            // Idle clock tracks cpol with no extra cycle of lag.
            sclk_d = cpol_d;
        end
    end

    assign cs_n_d = ~cs_assert_d;
    assign irq_d  = irq_en_q & rx_valid_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cs_assert_q <= 1'b0;
            irq_en_q    <= 1'b0;
            cpol_q      <= 1'b0;
            div_q       <= DIV_RESET;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            wr_col_q    <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_byte_q   <= '0;
            edge_cnt_q  <= '0;
            div_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cs_assert_q <= cs_assert_d;
            irq_en_q    <= irq_en_d;
            cpol_q      <= cpol_d;
            div_q       <= div_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            wr_col_q    <= wr_col_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_byte_q   <= rx_byte_d;
            edge_cnt_q  <= edge_cnt_d;
            div_cnt_q   <= div_cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign wb_if.ack   = ack_q;
    assign wb_if.rdata = rdata_q;
    assign wb_if.stall = 1'b0;
    assign wb_if.err   = 1'b0;
    assign wb_if.rty   = 1'b0;

    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_spi_ctrl.sv
// Directed bench for wb_spi_ctrl: register vector table plus SPI transfer sequences.
// Latency: drives requests on the falling edge and samples responses one falling edge later.
// Backpressure: none expected; bounded polling loops guard every wait.
module tb_wb_spi_ctrl;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    logic spi_sclk, spi_mosi, spi_miso, spi_cs_n, spi_irq;
    logic loop_en = 1'b0;
    logic miso_val = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    wishbone_if wb();

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    wb_spi_ctrl #(.DIV_RESET(8'd3)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wb_if      (wb.SLAVE),
        .spi_sclk_o (spi_sclk),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso),
        .spi_cs_n_o (spi_cs_n),
        .irq_o      (spi_irq)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic ack_v, output logic [31:0] rd_v);
        @(negedge clk_i);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we_v;
        wb.addr = a; wb.wdata = d; wb.sel = s;
        @(negedge clk_i);
        ack_v = wb.ack;
        rd_v  = wb.rdata;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d);
        logic k;
        logic [31:0] r;
        bus(1'b1, a, d, 4'hF, k, r);
        check({nm, "_ack"}, {31'b0, k}, 32'd1);
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic k;
        logic [31:0] r;
        bus(1'b0, a, 32'd0, 4'hF, k, r);
        check({nm, "_ack"}, {31'b0, k}, 32'd1);
        check(nm, r, exp);
    endtask

    // Back-to-back STATUS reads starting on the current falling edge until
    // busy is seen to drop; collects MOSI at each leading SCLK edge.
    task automatic poll(input int max_cyc, input logic cpol_v, output int busy_n,
                        output logic [31:0] first_st, output logic [31:0] last_st,
                        output logic [7:0] mosi_byte, output logic irq_last_busy,
                        output logic irq_done);
        logic prev;
        logic done;
        busy_n = 0; first_st = '0; last_st = '0; mosi_byte = '0;
        irq_last_busy = 1'b0; irq_done = 1'b0; done = 1'b0;
        prev = spi_sclk;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 32'hC; wb.sel = 4'hF;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk_i);
            if (prev == cpol_v && spi_sclk != cpol_v) mosi_byte = {mosi_byte[6:0], spi_mosi};
            prev = spi_sclk;
            if (i == 0) first_st = wb.rdata;
            if (wb.ack && wb.rdata[0]) begin
                busy_n++;
                irq_last_busy = spi_irq;
            end else if (busy_n > 0) begin
                done = 1'b1;
                last_st = wb.rdata;
                irq_done = spi_irq;
            end
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
        check("poll_done", {31'b0, done}, 32'd1);
    endtask

    int          bn;
    logic [31:0] fst, lst;
    logic [7:0]  mb;
    logic        ilb, idn;
    logic        k;
    logic [31:0] r;

    initial begin
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.addr = '0; wb.wdata = '0; wb.sel = '0;

        tbl[0]  = '{1'b0, 32'h0,  32'h0,        4'hF, 32'h0};
        tbl[1]  = '{1'b0, 32'h4,  32'h0,        4'hF, 32'h3};
        tbl[2]  = '{1'b0, 32'h8,  32'h0,        4'hF, 32'h0};
        tbl[3]  = '{1'b0, 32'hC,  32'h0,        4'hF, 32'h0};
        tbl[4]  = '{1'b1, 32'h0,  32'h5,        4'hF, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,  32'h0,        4'hF, 32'h5};
        tbl[6]  = '{1'b1, 32'h4,  32'h1FF,      4'hF, 32'h0};
        tbl[7]  = '{1'b0, 32'h4,  32'h0,        4'hF, 32'hFF};
        tbl[8]  = '{1'b1, 32'h4,  32'h22,       4'hE, 32'h0};
        tbl[9]  = '{1'b0, 32'h4,  32'h0,        4'hF, 32'hFF};
        tbl[10] = '{1'b1, 32'h0,  32'hFFFFFFF8, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 32'h0,  32'h0,        4'hF, 32'h0};
        tbl[12] = '{1'b1, 32'hC,  32'hF,        4'hF, 32'h0};
        tbl[13] = '{1'b0, 32'hC,  32'h0,        4'hF, 32'h0};
        tbl[14] = '{1'b1, 32'h4,  32'h1,        4'hF, 32'h0};
        tbl[15] = '{1'b0, 32'h14, 32'h0,        4'hF, 32'h1};
        tbl[16] = '{1'b1, 32'h0,  32'h1,        4'h1, 32'h0};
        tbl[17] = '{1'b0, 32'h0,  32'h0,        4'hF, 32'h1};

        // Reset state while held in reset
        #12;
        check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
        check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
        check("rst_irq",  {31'b0, spi_irq},  32'd0);
        check("rst_ack",  {31'b0, wb.ack},   32'd0);
        check("rst_rdata", wb.rdata, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Register table
        for (int i = 0; i < NVEC; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, k, r);
            check($sformatf("vec%0d_ack", i), {31'b0, k}, 32'd1);
            check($sformatf("vec%0d_rdata", i), r, tbl[i].exp);
        end
        check("cs_n_asserted", {31'b0, spi_cs_n}, 32'd0);
        check("sclk_idle_lo", {31'b0, spi_sclk}, 32'd0);

        // Loopback 0xA5, div=1
        loop_en = 1'b1;
        wr("a_data", 32'h8, 32'hA5);
        poll(200, 1'b0, bn, fst, lst, mb, ilb, idn);
        check("a_busy_cycles", 32'(bn), 32'd32);
        check("a_mosi_bits", {24'b0, mb}, 32'hA5);
        check("a_status_done", lst, 32'h2);
        rd("a_rx", 32'h8, 32'hA5);
        rd("a_status_clr", 32'hC, 32'h0);

        // cpol=1, irq_en, div=0, MISO tied high
        loop_en = 1'b0; miso_val = 1'b1;
        wr("b_ctrl", 32'h0, 32'h6);
        check("b_sclk_idle_hi", {31'b0, spi_sclk}, 32'd1);
        wr("b_div", 32'h4, 32'h0);
        wr("b_data", 32'h8, 32'h3C);
        poll(200, 1'b1, bn, fst, lst, mb, ilb, idn);
        check("b_busy_cycles", 32'(bn), 32'd16);
        check("b_irq_while_busy", {31'b0, ilb}, 32'd0);
        check("b_irq_after", {31'b0, idn}, 32'd1);
        check("b_sclk_end_hi", {31'b0, spi_sclk}, 32'd1);
        check("b_cs_n", {31'b0, spi_cs_n}, 32'd1);
        rd("b_rx", 32'h8, 32'hFF);
        @(negedge clk_i);
        check("b_irq_drop", {31'b0, spi_irq}, 32'd0);

        // Write collision, div=3, loopback
        loop_en = 1'b1;
        wr("c_ctrl", 32'h0, 32'h1);
        wr("c_div", 32'h4, 32'h3);
        wr("c_data", 32'h8, 32'h5A);
        wr("c_data_col", 32'h8, 32'hFF);
        rd("c_status_col", 32'hC, 32'h9);
        wr("c_w1c", 32'hC, 32'h8);
        rd("c_status_w1c", 32'hC, 32'h1);
        poll(300, 1'b0, bn, fst, lst, mb, ilb, idn);
        check("c_status_done", lst, 32'h2);
        rd("c_rx_unchanged", 32'h8, 32'h5A);

        // Overrun and read coinciding with completion, div=0
        wr("d_div", 32'h4, 32'h0);
        wr("d_data1", 32'h8, 32'h11);
        poll(100, 1'b0, bn, fst, lst, mb, ilb, idn);
        wr("d_data2", 32'h8, 32'h22);
        poll(100, 1'b0, bn, fst, lst, mb, ilb, idn);
        check("d_status_ovr", lst, 32'h6);
        rd("d_rx2", 32'h8, 32'h22);
        wr("d_data3", 32'h8, 32'h33);
        repeat (15) @(negedge clk_i);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 32'h8; wb.sel = 4'hF;
        @(negedge clk_i);
        check("d_coinc_ack", {31'b0, wb.ack}, 32'd1);
        check("d_coinc_old", wb.rdata, 32'h22);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        rd("d_status_valid", 32'hC, 32'h6);
        rd("d_rx3", 32'h8, 32'h33);
        wr("d_clr_ovr", 32'hC, 32'h4);
        rd("d_status_clr", 32'hC, 32'h0);

        // Reset at edge 7 of a div=0 transfer
        wr("e_data", 32'h8, 32'hFF);
        repeat (7) @(posedge clk_i);
        #2;
        check("e_sclk_pre", {31'b0, spi_sclk}, 32'd1);
        rstn_i = 1'b0;
        #1;
        check("e_rst_sclk", {31'b0, spi_sclk}, 32'd0);
        check("e_rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
        check("e_rst_mosi", {31'b0, spi_mosi}, 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        rd("e_status", 32'hC, 32'h0);
        rd("e_div", 32'h4, 32'h3);
        rd("e_ctrl", 32'h0, 32'h0);
        wr("e_ctrl_w", 32'h0, 32'h1);
        wr("e_div_w", 32'h4, 32'h1);
        wr("e_data_w", 32'h8, 32'hC3);
        poll(200, 1'b0, bn, fst, lst, mb, ilb, idn);
        check("e_busy_cycles", 32'(bn), 32'd32);
        check("e_mosi_bits", {24'b0, mb}, 32'hC3);
        rd("e_rx", 32'h8, 32'hC3);

        // Four back-to-back STATUS reads
        @(negedge clk_i);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 32'hC; wb.sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("f_ack%0d", i), {31'b0, wb.ack}, 32'd1);
            check($sformatf("f_stall%0d", i), {31'b0, wb.stall}, 32'd0);
            check($sformatf("f_rdata%0d", i), wb.rdata, 32'h0);
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(negedge clk_i);
        check("f_ack_low", {31'b0, wb.ack}, 32'd0);
        check("f_rdata_low", wb.rdata, 32'h0);
        check("f_err_rty", {30'b0, wb.err, wb.rty}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_spi_ctrl.md
WB_SPI_CTRL -- requirements
Module: wb_spi_ctrl

Interface
REQ-001 SHALL have parameter DIV_RESET, default 8'd3, giving the reset value of DIV.
REQ-002 SHALL have port clk_i  in  1  the single clock for all logic.
REQ-003 SHALL have port rstn_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have port wb_if  wishbone_if.SLAVE  -  pipelined Wishbone responder: cyc, stb, we, addr[31:0], wdata[31:0] and sel[3:0] in; rdata[31:0], ack, stall, err and rty out.
REQ-005 SHALL have port spi_sclk_o  out  1  SPI clock.
REQ-006 SHALL have port spi_mosi_o  out  1  serial data out, MSB first.
REQ-007 SHALL have port spi_miso_i  in  1  serial data in.
REQ-008 SHALL have port spi_cs_n_o  out  1  chip select, active low.
REQ-009 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-010 Register map SHALL be decoded on addr[3:2] only: 0 CTRL, 1 DIV, 2 DATA, 3 STATUS.
- CTRL bit0 = cs_assert, bit1 = irq_en, bit2 = cpol.
- DIV bits[7:0] = div.
- STATUS bit0 = busy, bit1 = rx_valid, bit2 = overrun, bit3 = wr_col.
- Unused read bits SHALL return 0.
REQ-011 stall, err and rty SHALL be tied to 0.
REQ-012 Every cycle with cyc&stb SHALL be accepted, with ack asserted exactly one cycle later for one cycle; back-to-back requests SHALL be acked on consecutive cycles.
REQ-013 rdata SHALL be registered and valid in the ack cycle, and SHALL be 0 when ack is low.
REQ-014 Writes SHALL take effect only when sel[0]=1; bits above 7 SHALL be ignored.
REQ-015 cs_assert SHALL drive spi_cs_n_o = ~cs_assert, registered, and SHALL take effect immediately even when busy.
REQ-016 Writes to cpol or div while busy SHALL be ignored; both SHALL be latched at transfer start.
REQ-017 FSM states SHALL be IDLE and XFER.
REQ-018 IDLE -> XFER on an accepted DATA write:
- load the tx shift register with wdata[7:0];
- spi_mosi_o = wdata[7] the next cycle;
- edge counter = 0, divider = 0, busy = 1.
REQ-019 In XFER, the divider SHALL count 0..div; at div it SHALL wrap to 0 and toggle spi_sclk_o (one edge).
REQ-020 Odd edges (1, 3, ...15) SHALL sample spi_miso_i into the rx shift register LSB.
REQ-021 Even edges (2, 4, ...14) SHALL shift tx and drive the next bit on spi_mosi_o.
REQ-022 Edge 16 SHALL return to IDLE with:
- spi_sclk_o = cpol;
- rx byte copied to the rx holding register;
- rx_valid = 1, busy = 0.
REQ-023 Total transfer SHALL take 16*(div+1) cycles from the cycle after write acceptance to busy=0.
REQ-024 In IDLE, spi_sclk_o SHALL equal cpol and spi_mosi_o SHALL hold its last value.
REQ-025 A DATA read SHALL return {24'b0, rx byte} and clear rx_valid.
REQ-026 If a DATA read coincides with completion, the read SHALL return the old byte and rx_valid SHALL end at 1.
REQ-027 Completion while rx_valid=1 SHALL set overrun and overwrite the rx byte.
REQ-028 A DATA write while busy SHALL be acked, ignored, and SHALL set wr_col.
REQ-029 STATUS writes with bit2/bit3 = 1 SHALL clear overrun/wr_col (W1C); busy and rx_valid SHALL be read-only.
REQ-030 irq_o SHALL equal irq_en & rx_valid, registered.
REQ-031 div=0 SHALL yield an SCLK edge every cycle, giving 16-cycle transfers.

Reset
REQ-032 On rstn_i low, asynchronously and including mid-transfer, the block SHALL enter IDLE with:
- spi_sclk_o = 0, spi_mosi_o = 0, spi_cs_n_o = 1;
- ack = 0, rdata = 0, irq_o = 0;
- CTRL = 0, DIV = DIV_RESET;
- shift registers, rx byte and all STATUS bits = 0.
REQ-033 After reset release, the first request SHALL be acked normally.

Verification
REQ-034 Write CTRL = 0x1, DIV = 1, DATA = 0xA5, with a MISO loopback from MOSI:
- spi_cs_n_o = 0;
- MOSI pattern 1,0,1,0,0,1,0,1;
- busy = 1 for exactly 32 cycles;
- then DATA read = 0x000000A5 and STATUS bit1 clears.
REQ-035 CTRL = 0x6, div = 0, DATA = 0x3C with MISO tied 1:
- sclk idles high;
- transfer lasts 16 cycles;
- rx = 0xFF;
- irq_o rises 1 cycle after busy falls, and drops after the DATA read.
REQ-036 DATA write during busy -> ack after 1 cycle, transfer unchanged, STATUS = 0x9; writing STATUS = 0x8 -> STATUS = 0x1.
REQ-037 Two transfers with no intermediate read -> STATUS bit2 = 1 and DATA returns the second byte; a DATA read in the completion cycle returns the old byte and rx_valid = 1.
REQ-038 rstn_i pulsed low at edge 7 of a transfer -> the same cycle shows sclk = 0, cs_n = 1, STATUS = 0, DIV = DIV_RESET; the next DATA write starts a clean 8-bit transfer.
REQ-039 Four back-to-back STATUS reads with cyc held -> four consecutive acks with stall = 0; a write with sel = 4'b1110 to DIV leaves DIV unchanged.
